uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial transmitter that sits directly downstream of the host-side command/driver stage and consumes its byte stream. It takes a byte on a valid/accept handshake, then frames and shifts it out on a single UART line: start bit, 8 data bits LSB first, optional parity, then stop bit(s). Its one-cycle accept pulse is what retires the upstream held byte and advances the upstream shift register.

Parameters:
CLKS_PER_BIT, 87, i_clk cycles per serial bit; legal range 2..65535; counter width is clog2(CLKS_PER_BIT).
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  asynchronous, active-low reset.
i_valid  input  1  upstream byte is available; held high until accepted.
i_data  input  8  byte to send; sampled only on the accepting edge.
o_accept  output  1  single-cycle pulse: byte has been taken.
o_tx  output  1  serial line; idles high.
o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, o_tx=1, o_accept=0, o_busy=0, bit and cycle counters=0, shift register=0. Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: o_tx=1. On an edge with i_valid=1:
  - latch i_data into the shift register;
  - go to START and clear the cycle counter;
  - set o_accept=1 and o_tx=0 for the following cycle.
  - i_valid=0: stay in IDLE.
- o_accept is high for exactly one cycle: the first cycle of START. It is never asserted in any other state.
  - The upstream stage drops i_valid on the edge that ends that cycle.
  - i_valid seen high during START/DATA/PARITY/STOP is ignored and does not re-accept.
- Bit timing: each bit is driven for exactly CLKS_PER_BIT cycles. The cycle counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
- START: o_tx=0 for one bit time, then go to DATA with bit index 0.
- DATA: o_tx=shift[0]; shift right at each bit boundary. After bit index 7 completes:
  - PARITY!=0: go to PARITY;
  - otherwise go to STOP.
- PARITY: o_tx = XOR of the 8 data bits (even), or its inverse (odd). Parity is computed from the latched byte, not from the live i_data. Lasts one bit time, then go to STOP.
- STOP: o_tx=1 for STOP_BITS bit times, then go to IDLE.
- Back-to-back: the accept check happens only in IDLE. The minimum gap between frames is one idle cycle with o_tx=1 beyond the stop bit(s).
- Frame length in cycles: (1 + 8 + (PARITY?1:0) + STOP_BITS) x CLKS_PER_BIT.
- Latency: from the accepting edge to the first o_tx=0 cycle is 0 cycles (o_tx is low starting the cycle after that edge).
- o_busy=1 from the first START cycle through the last STOP cycle inclusive.
- i_data may change freely after acceptance without affecting the frame in flight.

Test Plan:
- Reset idle (CLKS_PER_BIT=4): hold reset, release, keep i_valid=0 for 100 cycles -> o_tx=1, o_busy=0, o_accept=0 throughout.
- Single byte (CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1): i_valid=1 with i_data=0xA5 for one cycle, then dropped on accept -> o_accept high exactly 1 cycle. o_tx sequence, 4 cycles per bit, is 0 | 1,0,1,0,0,1,0,1 | 1. o_busy high for 40 cycles.
- Parity (PARITY=1 then 2, i_data=0xA5 and 0x07) -> even parity bits 0 and 1; odd parity bits 1 and 0. Frame is 44 cycles with STOP_BITS=1.
- Back-to-back with held valid: upstream model re-asserts i_valid=1 with 0x3C immediately after the first accept -> no second o_accept until IDLE. The second start bit begins exactly 1 idle cycle after the last stop cycle. The second frame decodes to 0x3C.
- Busy-ignore and data stability: toggle i_data randomly and pulse i_valid during a 0x00 frame -> transmitted bits remain all zeros and no extra o_accept occurs.
- Reset mid-frame: assert i_rst_n=0 during DATA bit 3 of 0xFF -> o_tx=1 and o_busy=0 asynchronously. After release, a new 0x81 frame transmits correctly with STOP_BITS=2 (stop high for 8 cycles).

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: byte-at-a-time UART transmitter.
// Frames start, 8 data bits LSB first, optional parity and stop bit(s).
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY       = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          acc_q, acc_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  assign bit_end  = (cnt_q == CNT_MAX);
  assign o_tx     = tx_q;
  assign o_accept = acc_q;
  assign o_busy   = busy_q;

  // State, counters and registered line outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic; outputs change only at bit edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    acc_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (i_valid) begin
          state_d = S_START;
          shift_d = i_data;
          par_d   = (PARITY == 2) ? ~^i_data : ^i_data;
          tx_d    = 1'b0;
          acc_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// Four instances cover parity none/even/odd and two stop bits.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_v [4];
  logic [7:0] data_v  [4];
  logic       acc_v   [4];
  logic       tx_v    [4];
  logic       busy_v  [4];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         sel;
  bit         mon_en;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (g == 3 ? 2 : 1),
      .PARITY      (g == 1 ? 1 : (g == 2 ? 2 : 0))
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (valid_v[g]),
      .i_data  (data_v[g]),
      .o_accept(acc_v[g]),
      .o_tx    (tx_v[g]),
      .o_busy  (busy_v[g])
    );
  end

  function automatic int par_of(input int s);
    return (s == 1) ? 1 : ((s == 2) ? 2 : 0);
  endfunction

  function automatic int stop_of(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] b, input bit push);
    int t;
    data_v[k]  = b;
    valid_v[k] = 1'b1;
    if (push) exp_q.push_back(b);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!acc_v[k] && t < 50);
    check("acc_seen", 32'(acc_v[k]), 32'd1);
    valid_v[k] = 1'b0;
    data_v[k]  = 8'($urandom);
    @(negedge clk);
    check("acc_pulse", 32'(acc_v[k]), 32'd0);
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while (busy_v[k] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(t < 300), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Frame monitor: samples every cycle of a frame and decodes it.
  initial begin : mon
    logic       fr [64];
    int         p, s, nb, len, glitch, busy_bad, stop_bad;
    logic [7:0] got, expb;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && !tx_v[sel]) begin
        p        = par_of(sel);
        s        = stop_of(sel);
        nb       = 9 + ((p != 0) ? 1 : 0) + s;
        len      = nb * CPB;
        fr[0]    = tx_v[sel];
        busy_bad = busy_v[sel] ? 0 : 1;
        for (int i = 1; i < len; i++) begin
          @(negedge clk);
          fr[i] = tx_v[sel];
          if (!busy_v[sel]) busy_bad++;
        end
        @(negedge clk);
        check("idle_after", 32'({busy_v[sel], tx_v[sel]}), 32'b01);
        glitch = 0;
        for (int b = 0; b < nb; b++)
          for (int j = 1; j < CPB; j++)
            if (fr[b*CPB+j] !== fr[b*CPB]) glitch++;
        for (int i = 0; i < 8; i++) got[i] = fr[(1+i)*CPB];
        stop_bad = 0;
        for (int i = 0; i < s; i++)
          if (fr[(nb-s+i)*CPB] !== 1'b1) stop_bad++;
        check("start_bit", 32'(fr[0]), 32'd0);
        check("bit_width", glitch, 0);
        check("busy_len", busy_bad, 0);
        check("stop_bits", stop_bad, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
        end else begin
          expb = exp_q.pop_front();
          check("data", 32'(got), 32'(expb));
          if (p != 0)
            check("parity", 32'(fr[9*CPB]),
                  32'((p == 2) ? ~^expb : ^expb));
        end
      end
    end
  end

  // Directed sequence; expected bytes flow through exp_q.
  initial begin : stim
    int t, n_acc;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    sel    = 0;
    for (int k = 0; k < 4; k++) begin
      valid_v[k] = 1'b0;
      data_v[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_state", 32'({tx_v[3], busy_v[3], acc_v[3]}), 32'b100);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle", 32'({tx_v[0], busy_v[0], acc_v[0]}), 32'b100);
    end
    mon_en = 1'b1;

    sel = 0;
    send(0, 8'hA5, 1'b1);
    wait_idle(0);

    sel = 1;
    send(1, 8'hA5, 1'b1);
    wait_idle(1);
    send(1, 8'h07, 1'b1);
    wait_idle(1);
    sel = 2;
    send(2, 8'hA5, 1'b1);
    wait_idle(2);
    send(2, 8'h07, 1'b1);
    wait_idle(2);

    sel = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'hA5;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!acc_v[0] && t < 50);
    check("b2b_acc1", 32'(acc_v[0]), 32'd1);
    data_v[0] = 8'h3C;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!acc_v[0] && t < 100);
    check("b2b_gap", t, 41);
    valid_v[0] = 1'b0;
    wait_idle(0);

    send(0, 8'h00, 1'b1);
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (acc_v[0]) n_acc++;
      data_v[0]  = 8'($urandom);
      valid_v[0] = 1'($urandom_range(0, 1));
    end
    valid_v[0] = 1'b0;
    check("busy_ignore", n_acc, 0);
    wait_idle(0);

    mon_en = 1'b0;
    sel    = 3;
    send(3, 8'hFF, 1'b0);
    repeat (16) @(negedge clk);
    check("mid_busy", 32'(busy_v[3]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx_v[3]), 32'd1);
    check("rst_busy", 32'(busy_v[3]), 32'd0);
    check("rst_acc", 32'(acc_v[3]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    send(3, 8'h81, 1'b1);
    wait_idle(3);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
